// File: rtl/i2c_byte_ctrl.sv
`timescale 1ns/1ps
// i2c_byte_ctrl: one byte command -> 9 MSB-first bit requests (8 data + ACK) -> one response pulse.
// Latency: accept +1 cycle, then ISSUE/WAIT_DONE per bit, then a 1-cycle RESP; cmd_ready only in IDLE,
// no response backpressure. Define I2C_BYTE_TIMEOUT_EN for a per-bit watchdog of TIMEOUT_CYCLES.
module i2c_byte_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic       i_cmd_read,
  input  logic [7:0] i_cmd_data,
  input  logic       i_cmd_nack,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_ack,
  output logic       o_rsp_timeout,
  output logic       o_busy,
  output logic       o_bit_req,
  output logic       o_bit_we,
  output logic       o_bit_wr_bit,
  input  logic       i_bit_ready,
  input  logic       i_bit_rd_valid,
  input  logic       i_bit_rd_bit
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("i2c_byte_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       read_q, read_d;
  logic       nack_q, nack_d;
  logic       samp_q, samp_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_ack_q, rsp_ack_d;
  logic       rsp_timeout_q, rsp_timeout_d;

  logic       ack_bit;
  logic       bit_we;
  logic       samp_sel;
  logic       wd_hit;

  assign ack_bit  = (bit_cnt_q == 4'd8);
  // Writes drive the 8 data bits and release SDA for the ACK; reads do the opposite.
  assign bit_we   = read_q ? ack_bit : ~ack_bit;
  assign samp_sel = i_bit_rd_valid ? i_bit_rd_bit : samp_q;

`ifdef I2C_BYTE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_count;

  assign wd_count = ((state_q == S_ISSUE) || (state_q == S_WAIT_DONE)) && !i_bit_ready;
  // Fires on the cycle that brings the stall count up to TIMEOUT_CYCLES.
  assign wd_hit   = wd_count && (wd_q >= WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d = wd_q;
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_count && (wd_q != WD_W'(TIMEOUT_CYCLES))) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    read_d        = read_q;
    nack_d        = nack_q;
    samp_d        = samp_q;
    rsp_data_d    = rsp_data_q;
    rsp_ack_d     = rsp_ack_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      S_IDLE: begin
        if (i_cmd_valid) begin
          read_d    = i_cmd_read;
          nack_d    = i_cmd_nack;
          shift_d   = i_cmd_data;
          bit_cnt_d = 4'd0;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        // An unstrobed released bit reads as a released (high) line.
        samp_d = 1'b1;
        if (wd_hit) begin
          state_d       = S_RESP;
          rsp_data_d    = 8'h00;
          rsp_ack_d     = 1'b0;
          rsp_timeout_d = 1'b1;
        end else if (i_bit_ready) begin
          state_d = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (!bit_we && i_bit_rd_valid) begin
          samp_d = i_bit_rd_bit;
        end
        if (wd_hit) begin
          state_d       = S_RESP;
          rsp_data_d    = 8'h00;
          rsp_ack_d     = 1'b0;
          rsp_timeout_d = 1'b1;
        end else if (i_bit_ready) begin
          if (ack_bit) begin
            state_d       = S_RESP;
            rsp_data_d    = read_q ? shift_q : 8'h00;
            rsp_ack_d     = read_q ? ~nack_q : ~samp_sel;
            rsp_timeout_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            shift_d   = read_q ? {shift_q[6:0], samp_sel} : {shift_q[6:0], 1'b0};
            state_d   = S_ISSUE;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      read_q        <= 1'b0;
      nack_q        <= 1'b0;
      samp_q        <= 1'b0;
      rsp_data_q    <= 8'h00;
      rsp_ack_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      read_q        <= read_d;
      nack_q        <= nack_d;
      samp_q        <= samp_d;
      rsp_data_q    <= rsp_data_d;
      rsp_ack_q     <= rsp_ack_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign o_cmd_ready   = (state_q == S_IDLE);
  assign o_busy        = (state_q != S_IDLE);
  assign o_bit_req     = (state_q == S_ISSUE) && !wd_hit;
  assign o_bit_we      = (state_q == S_ISSUE) && bit_we;
  assign o_bit_wr_bit  = (state_q == S_ISSUE) && bit_we && (read_q ? nack_q : shift_q[7]);
  assign o_rsp_valid   = (state_q == S_RESP);
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_ack     = rsp_ack_q;
  assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_i2c_byte_ctrl.sv
`timescale 1ns/1ps
// Bench for i2c_byte_ctrl: randomized byte commands against a bit-generator/slave model,
// with expected bits and responses queued at issue time and checked by independent processes.
module tb_i2c_byte_ctrl;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_read, cmd_nack;
  logic [7:0] cmd_data;
  logic       bit_ready, rd_valid, rd_bit;
  logic       o_cmd_ready, o_rsp_valid, o_rsp_ack, o_rsp_timeout, o_busy;
  logic       o_bit_req, o_bit_we, o_bit_wr_bit;
  logic [7:0] o_rsp_data;

  typedef struct { logic we; logic wr; logic rd; } bit_exp_t;
  typedef struct { logic [7:0] data; logic ack; logic to; } rsp_exp_t;

  bit_exp_t bitq[$];
  rsp_exp_t rspq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int seen_bits = 0;
  int exp_bits = 0;
  int last_rsp_cyc = 0;
  int stick_at = -1;
  bit bm_en = 1'b1;
  bit prev_hold = 1'b0;
`ifdef I2C_BYTE_TIMEOUT_EN
  int acc_cyc = 0;
`endif

  i2c_byte_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_read    (cmd_read),
    .i_cmd_data    (cmd_data),
    .i_cmd_nack    (cmd_nack),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_data    (o_rsp_data),
    .o_rsp_ack     (o_rsp_ack),
    .o_rsp_timeout (o_rsp_timeout),
    .o_busy        (o_busy),
    .o_bit_req     (o_bit_req),
    .o_bit_we      (o_bit_we),
    .o_bit_wr_bit  (o_bit_wr_bit),
    .i_bit_ready   (bit_ready),
    .i_bit_rd_valid(rd_valid),
    .i_bit_rd_bit  (rd_bit)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail(string nm);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // Reference model: a byte is data[7]..data[0] then the ACK slot, whoever drives it.
  // sack=1 means the slave pulls SDA low in the ACK slot of a write.
  // abort_after >= 0 models a bus that freezes after that many bits.
  task automatic push_cmd(input logic rd, input logic [7:0] d, input logic nk,
                          input logic [7:0] sb, input logic sack, input int abort_after);
    bit_exp_t e;
    rsp_exp_t r;
    int nbits;
    nbits = (abort_after >= 0) ? abort_after : 9;
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) begin
        e.we = !rd;
        e.wr = rd ? 1'b0 : d[7-i];
        e.rd = rd ? sb[7-i] : 1'b0;
      end else begin
        e.we = rd;
        e.wr = rd ? nk : 1'b0;
        e.rd = rd ? 1'b0 : !sack;
      end
      bitq.push_back(e);
    end
    exp_bits += nbits;
    if (abort_after >= 0) begin
      r.data = 8'h00; r.ack = 1'b0; r.to = 1'b1;
    end else begin
      r.data = rd ? sb : 8'h00;
      r.ack  = rd ? !nk : sack;
      r.to   = 1'b0;
    end
    rspq.push_back(r);
  endtask

  // Called and returns on a negedge; with hold=1 cmd_valid stays high for the next command.
  task automatic drive_cmd(input logic rd, input logic [7:0] d, input logic nk, input bit hold);
    int  t;
    bit  done;
    cmd_valid = 1'b1; cmd_read = rd; cmd_data = d; cmd_nack = nk;
    t = 0; done = 1'b0;
    while (!done && t < 1000) begin
      if (o_cmd_ready) begin
        if (prev_hold) chk("b2b_accept_cycle", cyc, last_rsp_cyc + 1);
        done = 1'b1;
      end
      @(negedge clk);
      t++;
    end
    if (!done) fail("cmd_accept_timeout");
    if (!hold) cmd_valid = 1'b0;
    prev_hold = hold;
  endtask

  task automatic issue(input logic rd, input logic [7:0] d, input logic nk,
                       input logic [7:0] sb, input logic sack, input bit hold);
    push_cmd(rd, d, nk, sb, sack, -1);
    drive_cmd(rd, d, nk, hold);
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((rspq.size() != 0 || bitq.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", rspq.size() + bitq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset(input string nm);
    chk(nm, {o_cmd_ready, o_busy, o_bit_req, o_bit_we, o_bit_wr_bit, o_rsp_valid,
             o_rsp_ack, o_rsp_timeout, o_rsp_data}, 32'h8000);
  endtask

  // Bit generator + slave: random accept stalls, busy time, repeated and ready-coincident strobes.
  initial begin : bit_model
    bit_exp_t e;
    int stall;
    int busy;
    bit dbl;
    bit same;
    bit skip;
    skip = 1'b0;
    bit_ready = 1'b1; rd_valid = 1'b0; rd_bit = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (!bm_en) begin bit_ready = 1'b0; rd_valid = 1'b0; continue; end
      if (!bit_ready) begin bit_ready = 1'b1; continue; end
      if (rst || o_bit_req !== 1'b1) continue;
      if (bitq.size() == 0) begin
        fail("bit_unexpected");
        e.we = 1'b0; e.wr = 1'b0; e.rd = 1'b1;
      end else begin
        e = bitq.pop_front();
      end
      chk("bit_we", o_bit_we, e.we);
      if (e.we) chk("bit_wr", o_bit_wr_bit, e.wr);
      stall = $urandom_range(0, 2);
      if (stall > 0) begin
        bit_ready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          chk("req_hold", o_bit_req, 1);
        end
        bit_ready = 1'b1;
      end
      @(negedge clk);
      seen_bits++;
`ifdef I2C_BYTE_TIMEOUT_EN
      acc_cyc = cyc;
`endif
      chk("req_drop", o_bit_req, 0);
      if (seen_bits == stick_at) begin
        bit_ready = 1'b0;
        while (stick_at >= 0) @(negedge clk);
        bit_ready = 1'b1;
        skip = 1'b1;
        continue;
      end
      busy = $urandom_range(1, 3);
      dbl  = (busy > 1) && ($urandom_range(0, 1) == 1);
      same = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < busy; i++) begin
        bit_ready = (i == busy - 1) && same;
        rd_valid  = !e.we && ((i == busy - 1) || (dbl && i == 0));
        rd_bit    = (i == busy - 1) ? e.rd : !e.rd;
        @(negedge clk);
      end
      rd_valid = 1'b0;
      bit_ready = 1'b1;
      skip = 1'b1;
    end
  end

  initial begin : monitor
    rsp_exp_t r;
    bit prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin prev_v = 1'b0; continue; end
      if (o_rsp_valid) begin
        last_rsp_cyc = cyc;
        chk("rsp_pulse_width", prev_v, 0);
        chk("cmd_ready_in_resp", o_cmd_ready, 0);
        chk("bit_req_in_resp", o_bit_req, 0);
        if (rspq.size() == 0) begin
          fail("rsp_unexpected");
        end else begin
          r = rspq.pop_front();
          chk("rsp_data", o_rsp_data, r.data);
          chk("rsp_ack", o_rsp_ack, r.ack);
          chk("rsp_timeout", o_rsp_timeout, r.to);
        end
      end
      if (o_cmd_ready) chk("bit_req_in_idle", o_bit_req, 0);
      prev_v = o_rsp_valid;
    end
  end

  initial begin : guard
    #2000000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_data = 8'h00; cmd_nack = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset_state");
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b0);
    issue(1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
    issue(1'b1, 8'h00, 1'b0, 8'h96, 1'b0, 1'b0);
    issue(1'b1, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0);
    wait_drain();

    issue(1'b0, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b1);
    issue(1'b1, 8'h00, 1'b0, 8'h69, 1'b0, 1'b0);
    wait_drain();

    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    cmd_valid = 1'b0;
    prev_hold = 1'b0;
    wait_drain();

`ifdef I2C_BYTE_TIMEOUT_EN
    stick_at = seen_bits + 4;
    push_cmd(1'b0, 8'hC3, 1'b0, 8'h00, 1'b1, 4);
    drive_cmd(1'b0, 8'hC3, 1'b0, 1'b0);
    wait_drain();
    chk("timeout_latency", last_rsp_cyc - acc_cyc, TO);
    stick_at = -1;
    repeat (3) @(negedge clk);
`endif

    // Abort a byte with reset while it is stuck in ISSUE.
    bm_en = 1'b0;
    repeat (3) @(negedge clk);
    drive_cmd(1'b0, 8'hF0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("busy_before_reset", {o_busy, o_bit_req}, 2'b11);
    rst = 1'b1;
    @(negedge clk);
    check_reset("reset_mid_byte");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_reset("idle_after_reset");
    bm_en = 1'b1;
    repeat (3) @(negedge clk);

    issue(1'b1, 8'h00, 1'b0, 8'h3A, 1'b0, 1'b0);
    issue(1'b0, 8'h81, 1'b0, 8'h00, 1'b1, 1'b0);
    wait_drain();
    chk("bit_request_count", seen_bits, exp_bits);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
